// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings and helpers for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH);

    // Divide-family ops occupy the upper half of the encoding.
    function automatic logic is_div(input md_op_t op);
        return op[2];
    endfunction

    // rs1 is treated as two's complement.
    function automatic logic is_signed_a(input md_op_t op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as two's complement.
    function automatic logic is_signed_b(input md_op_t op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Result comes from the upper accumulator half: product high word or remainder.
    function automatic logic takes_high(input md_op_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU) ||
               (op == MD_REM) || (op == MD_REMU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or one restoring-subtract iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Multiply: hi:lo shifts right with the partial sum; divide: remainder:quotient shifts left.
    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH + 1){1'b0}});
        shifted = {hi, lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            hi_next = fits ? diff : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = add_sum[WIDTH:1];
            lo_next = {add_sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, optional MULDIV_EARLY_OUT_EN
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t        state_q;
    md_state_t        state_d;
    md_op_t           op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fix_phase_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic             neg_a;
    logic             neg_b;
    logic             neg_quot;
    logic [WIDTH-1:0] fixed_sel;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div(op_q)),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (divisor_q),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

    md_op_t           in_op;
    logic             in_a_zero;
    logic             in_b_zero;
    logic             in_ovf;
    logic             early_hit;
    logic [WIDTH-1:0] early_val;

    // Trivial operands and the RISC-V special cases resolve straight from the inputs.
    always_comb begin
        in_op     = md_op_t'(op);
        in_a_zero = (A == '0);
        in_b_zero = (B == '0);
        in_ovf    = ((in_op == MD_DIV) || (in_op == MD_REM)) && (A == MOST_NEG) && (B == '1);
        early_hit = in_a_zero || in_b_zero || in_ovf;
        early_val = '0;
        if (is_div(in_op) && in_b_zero) begin
            early_val = takes_high(in_op) ? A : '1;
        end else if (in_ovf) begin
            early_val = takes_high(in_op) ? '0 : A;
        end
    end
`endif

    // Sign handling: operand signs from the latched op, quotient sign suppressed on divide-by-zero.
    always_comb begin
        neg_a     = a_q[WIDTH-1] && is_signed_a(op_q);
        neg_b     = b_q[WIDTH-1] && is_signed_b(op_q);
        neg_quot  = (sign_a_q ^ sign_b_q) && (b_q != '0);
        fixed_sel = takes_high(op_q) ? hi_q : lo_q;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; FIX spends two cycles (negate, then select and zero-detect).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef MULDIV_EARLY_OUT_EN
                    state_d = early_hit ? ST_DONE : ST_PREP;
`else
                    state_d = ST_PREP;
`endif
                end
            end
            ST_PREP: state_d = ST_CALC;
            ST_CALC: begin
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (fix_phase_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, magnitude prep, iteration and sign fix-up datapath.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            op_q        <= MD_MUL;
            a_q         <= '0;
            b_q         <= '0;
            divisor_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            cnt_q       <= '0;
            fix_phase_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q <= md_op_t'(op);
                        a_q  <= A;
                        b_q  <= B;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_hit) begin
                            result_q <= early_val;
                            zero_q   <= (early_val == '0);
                        end
`endif
                    end
                end
                ST_PREP: begin
                    sign_a_q    <= neg_a;
                    sign_b_q    <= neg_b;
                    hi_q        <= '0;
                    lo_q        <= neg_a ? -a_q : a_q;
                    divisor_q   <= neg_b ? -b_q : b_q;
                    cnt_q       <= CNT_W'(WIDTH - 1);
                    fix_phase_q <= 1'b0;
                end
                ST_CALC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_FIX: begin
                    if (!fix_phase_q) begin
                        if (is_div(op_q)) begin
                            if (neg_quot) begin
                                lo_q <= -lo_q;
                            end
                            if (sign_a_q) begin
                                hi_q <= -hi_q;
                            end
                        end else if (sign_a_q ^ sign_b_q) begin
                            {hi_q, lo_q} <= -{hi_q, lo_q};
                        end
                        fix_phase_q <= 1'b1;
                    end else begin
                        result_q    <= fixed_sel;
                        zero_q      <= (fixed_sel == '0);
                        fix_phase_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_cmp;
    int n_fail;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // RV32M semantics computed with 64-bit host arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'(signed'(av));
        sb = longint'(signed'(bv));
        ua = {32'd0, av};
        ub = {32'd0, bv};
        p  = '0;
        case (o)
            3'd0: p = sa * sb;
            3'd1: begin p = sa * sb; p = p >> 32; end
            3'd2: begin p = sa * longint'(ub); p = p >> 32; end
            3'd3: begin p = ua * ub; p = p >> 32; end
            3'd4: begin
                if (bv == 32'd0) p = '1;
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) p = {32'd0, av};
                else p = sa / sb;
            end
            3'd5: begin
                if (bv == 32'd0) p = '1;
                else p = ua / ub;
            end
            3'd6: begin
                if (bv == 32'd0) p = {32'd0, av};
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) p = '0;
                else p = sa % sb;
            end
            default: begin
                if (bv == 32'd0) p = {32'd0, av};
                else p = ua % ub;
            end
        endcase
        return p[31:0];
    endfunction

    function automatic logic is_early(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        return (av == 32'd0) || (bv == 32'd0) ||
               (((o == 3'd4) || (o == 3'd6)) && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF);
    endfunction

    function automatic logic lat_ok(input logic early, input int lat);
`ifdef MULDIV_EARLY_OUT_EN
        return early ? (lat <= 1) : (lat == 35);
`else
        return (lat == 35) && (early || !early);
`endif
    endfunction

    function automatic logic [31:0] rand_operand();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Drives one op starting #1 after an edge, waits (bounded) for the result, then consumes it.
    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] res, output logic zr, output int lat, output logic rdy_after);
        op       = o;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rdy_after = in_ready;
        lat       = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res       = result;
        zr        = zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
        n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b want=1", zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op  [9] = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] t_a   [9] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd20,
                                   32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [9] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd6,
                                   32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [9] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2,
                                   32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        logic        zr;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 9; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], res, zr, lat, rdy);
            n_cmp++; if (res !== t_exp[i]) begin n_fail++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res, t_exp[i]); end
            n_cmp++; if (zr !== (t_exp[i] == 32'd0)) begin n_fail++; $display("FAIL directed_zero[%0d] got=%b want=%b", i, zr, t_exp[i] == 32'd0); end
            n_cmp++; if (!lat_ok(is_early(t_op[i], t_a[i], t_b[i]), lat)) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d", i, lat); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp;
        logic [31:0] res;
        logic        zr;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 40; i++) begin
            o   = 3'($urandom_range(0, 7));
            av  = rand_operand();
            bv  = rand_operand();
            exp = ref_op(o, av, bv);
            do_op(o, av, bv, res, zr, lat, rdy);
            n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL random_result op=%0d a=%h b=%h got=%h want=%h", o, av, bv, res, exp); end
            n_cmp++; if (zr !== (exp == 32'd0)) begin n_fail++; $display("FAIL random_zero op=%0d got=%b want=%b", o, zr, exp == 32'd0); end
            n_cmp++; if (!lat_ok(is_early(o, av, bv), lat)) begin n_fail++; $display("FAIL random_latency op=%0d a=%h b=%h got=%0d", o, av, bv, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp;
        int          wait_cnt;
        av  = $urandom | 32'd1;
        bv  = $urandom | 32'd1;
        exp = ref_op(3'd1, av, bv);
        op = 3'd1; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (out_valid !== 1'b1 && wait_cnt < 200) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b want=1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            op = 3'd5; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++; if (result !== exp) begin n_fail++; $display("FAIL bp_hold_result[%0d] got=%h want=%h", i, result, exp); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_stays_idle got=%b want=1", in_ready); end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp;
        logic [31:0] res;
        logic        zr;
        int          lat;
        logic        rdy;
        op = 3'd4; a = $urandom; b = $urandom | 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (result !== 32'd0) begin n_fail++; $display("FAIL midrst_result got=%h want=0", result); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        av  = $urandom;
        bv  = $urandom | 32'd1;
        exp = ref_op(3'd6, av, bv);
        do_op(3'd6, av, bv, res, zr, lat, rdy);
        n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL midrst_after_result got=%h want=%h", res, exp); end
        n_cmp++; if (lat != 35) begin n_fail++; $display("FAIL midrst_after_latency got=%0d want=35", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] exp;
        logic [31:0] res;
        logic        zr;
        int          lat;
        logic        rdy;
        for (int i = 0; i < 3; i++) begin
            av  = $urandom | 32'd1;
            bv  = $urandom | 32'd1;
            exp = ref_op(3'(i), av, bv);
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_before[%0d] got=%b want=1", i, in_ready); end
            do_op(3'(i), av, bv, res, zr, lat, rdy);
            n_cmp++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after_accept[%0d] got=%b want=0", i, rdy); end
            n_cmp++; if (res !== exp) begin n_fail++; $display("FAIL b2b_result[%0d] got=%h want=%h", i, res, exp); end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = 32'd0;
        b         = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
